// File: rtl/prog_loader.sv
// Program loader / instruction store: clears memory to FILL_WORD, loads a host word stream, gates CPU start.
// Fetch latency 1 cycle; ins_ready drops when memory is full. Optional running load checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    parameter logic [WIDTH-1:0] FILL_WORD = WIDTH'(32'h00000013),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic             start,
    input  logic [AW-1:0]    fetch_addr,
    output logic [WIDTH-1:0] fetch_data,
    output logic             cpu_run,
    output logic             busy,
    output logic [AW:0]      word_count,
    output logic             overflow,
    output logic [WIDTH-1:0] checksum
);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOAD, S_READY, S_RUN} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t           state, state_nxt;
    logic [AW-1:0]    clr_addr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             enter_load;
    logic             full;
    logic             accept;

    assign full       = (count == FULL_CNT);
    assign accept     = ins_valid & ins_ready;
    assign word_count = count;

    always_comb begin
        state_nxt  = state;
        ins_ready  = 1'b0;
        cpu_run    = 1'b0;
        busy       = 1'b0;
        enter_load = 1'b0;
        case (state)
            S_CLEAR: begin
                busy = 1'b1;
                if (clr_addr == AW'(DEPTH-1)) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (load) begin
                    state_nxt  = S_LOAD;
                    enter_load = 1'b1;
                end
            end
            S_LOAD: begin
                ins_ready = !full;
                // An empty load only falls back to IDLE if no word lands on the exit edge.
                if (!load) state_nxt = (count == '0 && !ins_valid) ? S_IDLE : S_READY;
            end
            S_READY: begin
                if (load) begin
                    state_nxt  = S_LOAD;
                    enter_load = 1'b1;
                end else if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                cpu_run = 1'b1;
                if (load) begin
                    state_nxt  = S_LOAD;
                    enter_load = 1'b1;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) clr_addr <= clr_addr + 1'b1;
            if (enter_load) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (accept) begin
                count <= count + 1'b1;
            end else if (state == S_LOAD && ins_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == S_CLEAR) mem[clr_addr] <= FILL_WORD;
            else if (accept)      mem[count[AW-1:0]] <= ins;
        end
    end

    // Non-blocking read: a same-cycle write to fetch_addr is seen one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) fetch_data <= '0;
        else      fetch_data <= mem[fetch_addr];
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum;

    always_ff @(posedge clk) begin
        if (!rst)            sum <= '0;
        else if (enter_load) sum <= '0;
        else if (accept)     sum <= sum + ins;
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table-driven load sequence, directed corner cases and random traffic vs. a spec-level model.
module tb_prog_loader;
    localparam int D  = 128;
    localparam int AW = 7;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int MD_CLEAR = 0, MD_IDLE = 1, MD_LOAD = 2, MD_READY = 3, MD_RUN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0, ins_valid = 1'b0, start = 1'b0;
    logic [31:0]   ins = '0;
    logic [AW-1:0] fetch_addr = '0;
    logic          ins_ready, cpu_run, busy, overflow;
    logic [31:0]   fetch_data, checksum;
    logic [AW:0]   word_count;

    prog_loader #(.WIDTH(32), .DEPTH(D), .FILL_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .load(load), .ins(ins), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .start(start), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .cpu_run(cpu_run), .busy(busy),
        .word_count(word_count), .overflow(overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model, stated in terms of the loader's externally visible rules.
    int          m_mode = MD_CLEAR;
    logic [31:0] m_mem [D];
    bit          m_known [D];
    int          m_clr = 0, m_cnt = 0;
    bit          m_ovf = 0;
    logic [31:0] m_sum = '0, m_fd = '0;
    bit          m_fd_known = 1;

    task automatic m_enter_load();
        m_mode = MD_LOAD; m_cnt = 0; m_ovf = 0; m_sum = '0;
    endtask

    task automatic model_step();
        logic [31:0] fd_n;
        bit          fdk_n;
        if (!rst) begin
            m_mode = MD_CLEAR; m_clr = 0; m_cnt = 0; m_ovf = 0;
            m_sum = '0; m_fd = '0; m_fd_known = 1;
        end else begin
            fd_n  = m_mem[fetch_addr];
            fdk_n = m_known[fetch_addr];
            case (m_mode)
                MD_CLEAR: begin
                    m_mem[m_clr] = NOP; m_known[m_clr] = 1; m_clr++;
                    if (m_clr == D) m_mode = MD_IDLE;
                end
                MD_IDLE: if (load) m_enter_load();
                MD_LOAD: begin
                    if (ins_valid && m_cnt < D) begin
                        m_mem[m_cnt] = ins; m_known[m_cnt] = 1; m_cnt++; m_sum += ins;
                    end else if (ins_valid) begin
                        m_ovf = 1;
                    end
                    if (!load) m_mode = (m_cnt == 0) ? MD_IDLE : MD_READY;
                end
                MD_READY: begin
                    if (load) m_enter_load();
                    else if (start) m_mode = MD_RUN;
                end
                default: if (load) m_enter_load();
            endcase
            m_fd = fd_n; m_fd_known = fdk_n;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_cks;
`ifdef PROG_LOADER_CHECKSUM_EN
        exp_cks = m_sum;
`else
        exp_cks = '0;
`endif
        chk("busy",       32'(busy),       32'(m_mode == MD_CLEAR));
        chk("cpu_run",    32'(cpu_run),    32'(m_mode == MD_RUN));
        chk("ins_ready",  32'(ins_ready),  32'(m_mode == MD_LOAD && m_cnt < D));
        chk("word_count", 32'(word_count), 32'(m_cnt));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("checksum",   checksum,        exp_cks);
        if (m_fd_known) chk("fetch_data", fetch_data, m_fd);
    endtask

    // Inputs are set mid-cycle; outputs are sampled 2 time units after the edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #2;
        check_all();
    endtask

    typedef struct {
        logic        ld, st, vl;
        logic [31:0] in;
        logic [6:0]  fa;
        logic [7:0]  wc;
        logic        rdy, run;
        logic [31:0] fd;
    } vec_t;
    vec_t tbl [16];

    int          busy_n;
    int          offered;
    logic [31:0] first0;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        7'd0, 8'd0, 1'b1, 1'b0, NOP};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h01308093, 7'd0, 8'd1, 1'b1, 1'b0, NOP};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h00002103, 7'd0, 8'd2, 1'b1, 1'b0, 32'h01308093};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h003101B3, 7'd1, 8'd3, 1'b1, 1'b0, 32'h00002103};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h00100013, 7'd2, 8'd4, 1'b1, 1'b0, 32'h003101B3};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'hFE101DE3, 7'd6, 8'd5, 1'b1, 1'b0, NOP};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        7'd1, 8'd5, 1'b0, 1'b0, 32'h00002103};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        7'd4, 8'd5, 1'b0, 1'b0, 32'hFE101DE3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        7'd6, 8'd5, 1'b0, 1'b1, NOP};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        7'd3, 8'd5, 1'b0, 1'b1, 32'h00100013};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        7'd3, 8'd0, 1'b1, 1'b0, 32'h00100013};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h00000001, 7'd0, 8'd1, 1'b1, 1'b0, 32'h01308093};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        7'd0, 8'd1, 1'b0, 1'b0, 32'h00000001};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        7'd2, 8'd0, 1'b1, 1'b0, 32'h003101B3};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        7'd4, 8'd0, 1'b0, 1'b0, 32'hFE101DE3};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        7'd5, 8'd0, 1'b0, 1'b0, NOP};

        // Reset for two cycles, then count the busy window.
        fetch_addr = 7'd5;
        cyc();
        cyc();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_fetch", fetch_data, 32'h0);
        rst = 1'b1;
        busy_n = busy ? 1 : 0;
        for (int i = 0; i < 300 && busy; i++) begin
            cyc();
            if (busy) busy_n++;
        end
        chk("busy_cycles", 32'(busy_n), 32'(D));
        cyc();
        chk("clear_fetch5", fetch_data, NOP);
        chk("idle_run", 32'(cpu_run), 32'd0);

        // Table-driven load / start / reprogram sequence.
        for (int i = 0; i < 16; i++) begin
            load = tbl[i].ld; start = tbl[i].st; ins_valid = tbl[i].vl;
            ins = tbl[i].in; fetch_addr = tbl[i].fa;
            cyc();
            chk($sformatf("tbl%0d_wc", i),  32'(word_count), 32'(tbl[i].wc));
            chk($sformatf("tbl%0d_rdy", i), 32'(ins_ready),  32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_run", i), 32'(cpu_run),    32'(tbl[i].run));
            chk($sformatf("tbl%0d_fd", i),  fetch_data,      tbl[i].fd);
        end
        start = 1'b0; load = 1'b0; ins_valid = 1'b0;

        // Three-word load with checksum wrap, then start.
        load = 1'b1; cyc();
        ins_valid = 1'b1;
        ins = 32'h00000001; cyc();
        ins = 32'h00000002; cyc();
        ins = 32'hFFFFFFFF; cyc();
        ins_valid = 1'b0; load = 1'b0; cyc();
        chk("cks_wc", 32'(word_count), 32'd3);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("cks_value", checksum, 32'h00000002);
`else
        chk("cks_value", checksum, 32'h0);
`endif
        start = 1'b1; cyc();
        chk("start_run", 32'(cpu_run), 32'd1);
        start = 1'b0;

        // Reprogram from RUN, then overfill memory.
        load = 1'b1; cyc();
        chk("reprog_run", 32'(cpu_run), 32'd0);
        chk("reprog_wc", 32'(word_count), 32'd0);
        offered = 0;
        first0 = '0;
        for (int i = 0; i < 600 && offered < D + 2; i++) begin
            ins = $urandom;
            ins_valid = ($urandom_range(0, 3) != 0);
            if (ins_valid && offered == 0) first0 = ins;
            if (ins_valid) offered++;
            cyc();
        end
        ins_valid = 1'b0;
        chk("ovf_wc", 32'(word_count), 32'(D));
        chk("ovf_rdy", 32'(ins_ready), 32'd0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        load = 1'b0; fetch_addr = '0; cyc();
        cyc();
        chk("ovf_mem0", fetch_data, first0);

        // Reset in the middle of a load.
        load = 1'b1; cyc();
        ins_valid = 1'b1; ins = 32'hA5A5A5A5; cyc(); cyc();
        rst = 1'b0; cyc();
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_rdy", 32'(ins_ready), 32'd0);
        chk("midrst_wc", 32'(word_count), 32'd0);
        chk("midrst_fd", fetch_data, 32'h0);
        rst = 1'b1; load = 1'b0; ins_valid = 1'b0;
        busy_n = 1;
        for (int i = 0; i < 300 && busy; i++) begin
            cyc();
            if (busy) busy_n++;
        end
        chk("midrst_busy_cycles", 32'(busy_n), 32'(D));
        cyc();
        chk("midrst_recleared", fetch_data, NOP);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) load = ~load;
            start      = ($urandom_range(0, 3) == 0);
            ins_valid  = $urandom_range(0, 1);
            ins        = $urandom;
            fetch_addr = AW'($urandom_range(0, D - 1));
            rst        = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end
endmodule
